dcache_controller: RTL
======================

Name: dcache_controller

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller. It sits between the CPU load/store stage and data_memory and acts as the initiator on the memory interface. It serves CPU requests through a valid/ready handshake and issues word reads and writes to data_memory using a fixed multi-cycle access window. Read misses refill one 4-word line.

Parameters:
NUM_LINES, 16, number of cache lines; must be a power of 2.
MEM_LATENCY, 2, cycles each memory word access is held; must be at least 1.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
cpu_req_valid  input  1  CPU request present
cpu_req_write  input  1  1 = store, 0 = load
cpu_req_addr  input  32  byte address; bits [1:0] ignored
cpu_req_wdata  input  32  store data
cpu_req_ready  output  1  controller can accept a request
cpu_resp_valid  output  1  one-cycle pulse; load data valid, or store acknowledged
cpu_resp_rdata  output  32  load data; 0 when cpu_resp_valid=0
mem_store_instruction  output  1  write enable to data_memory
mem_address  output  32  byte address to data_memory
mem_data_in  output  32  write data to data_memory
mem_data_out  input  32  combinational read data from data_memory
hit_count  output  32  number of accepted requests that hit; wraps
miss_count  output  32  number of accepted requests that miss; wraps

Behaviour:
- Address split: offset = addr[3:2]; index = addr[4+log2(NUM_LINES)-1:4]; tag = the remaining upper bits.
- Per line storage: valid bit, tag, and 4 data words.
- FSM states: IDLE, REFILL, WRITE.
  - cpu_req_ready = 1 only in IDLE.
  - A request is accepted on an edge where valid & ready.
- Read hit, accepted at edge T:
  - Stay in IDLE.
  - cpu_resp_valid=1 with the word in cycle T+1.
  - Back-to-back hits sustain one request per cycle.
- Read miss at T:
  - Go to REFILL. Words k=0..3 are fetched at line_base+4k.
  - Each word holds mem_address for MEM_LATENCY cycles; mem_data_out is captured on the final edge of its window.
  - After word 3: set valid, write the tag, return to IDLE.
  - cpu_resp_valid in cycle T+4*MEM_LATENCY+1 with the requested word. The word comes from the refill data, not a re-read of the array.
- Write at T (hit or miss):
  - Go to WRITE and drive mem_address = {addr[31:2],2'b00} and mem_data_in = wdata for MEM_LATENCY cycles.
  - mem_store_instruction=1 only in the last cycle of that window, giving exactly one memory write.
  - On a hit, the cached word is updated at T.
  - On a miss, no allocation; the line is unchanged.
  - Ack pulse (cpu_resp_valid=1, rdata=0) in cycle T+MEM_LATENCY+1.
- In every response cycle the FSM is in IDLE with ready=1, so a new request may be accepted in the same cycle.
- A conflicting index evicts the old line silently. No dirty state exists.
- Counters increment by 1 on the acceptance edge and wrap at 2^32.
- mem_address holds its last value in IDLE. mem_store_instruction=0 outside the WRITE last-cycle pulse.
- Reset (reset=0), immediate and asynchronous:
  - State goes to IDLE; all valid bits and both counters clear.
  - cpu_resp_valid, mem_store_instruction, cpu_resp_rdata, mem_address and mem_data_in go to 0.
  - Any in-flight refill is abandoned with no partial line marked valid.
  - A write aborted before its store pulse never reaches memory.
- After reset release: cpu_req_ready=1 in IDLE.

Decomposition:
- Package dcache_pkg holds:
  - state encoding (IDLE, REFILL, WRITE)
  - OFFSET_W=2, INDEX_W=$clog2(NUM_LINES), TAG_W=32-4-INDEX_W
  - WORDS_PER_LINE=4
  - field-extract functions for offset, index and tag
- Sub-module dcache_line_array holds valid, tag and data storage:
  - combinational lookup with a hit output
  - synchronous word write and refill-word write ports
  - async clear of all valid bits
- The top module keeps the FSM, the latency and word counters, and the performance counters.

Test Plan:
- Bench memory preload: data_memory with mem[0]=DEADBEEF, mem[64]=CAFEBABE, mem[65]=00000099. MEM_LATENCY=2.
- Read 0x104 after reset -> resp at T+9, rdata=00000099, miss_count=1. Reads of 0x100/0x104/0x108/0x10C observed on mem_address, 2 cycles each.
- Then read 0x100 -> resp at T+1 = CAFEBABE, hit_count=1, no mem_address change. Two consecutive hits on consecutive cycles -> two consecutive resp pulses.
- Write 0x104=12345678 (hit) -> single mem_store_instruction pulse at T+2 with address 0x104, ack at T+3. Subsequent read 0x104 hits and returns 12345678.
- Write 0x200=AAAA5555 (miss) -> one memory store, then read 0x200 misses (miss_count increments). Read 0x0 evicts index 0 and returns DEADBEEF; the next read 0x100 misses again.
- Assert reset=0 during the third refill word of a 0x100 miss -> outputs zero immediately. After release, read 0x100 misses (no partial line valid) and both counters restart from 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-through data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REFILL = 2'd1,
      ST_WRITE  = 2'd2
   } state_e;

   localparam int OFFSET_W       = 2;
   localparam int WORDS_PER_LINE = 4;
   localparam int DEF_NUM_LINES  = 16;
   localparam int INDEX_W        = $clog2(DEF_NUM_LINES);
   localparam int TAG_W          = 32 - 4 - INDEX_W;

   function automatic logic [OFFSET_W-1:0] addr_offset(input logic [31:0] addr);
      return addr[3:2];
   endfunction

   // Index and tag are returned full-width so callers with any line count can truncate.
   function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w);
      return (addr >> 4) & ((32'd1 << index_w) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w);
      return addr >> (4 + index_w);
   endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage for the cache: combinational lookup, word and refill write ports,
// and asynchronous clearing of every valid bit.
module dcache_line_array
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 16,
   parameter int IDX_W     = $clog2(NUM_LINES),
   parameter int TG_W      = 28 - IDX_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IDX_W-1:0]    lk_idx_i,
   input  logic [TG_W-1:0]     lk_tag_i,
   input  logic [OFFSET_W-1:0] lk_off_i,
   output logic                lk_hit_o,
   output logic [31:0]         lk_rdata_o,
   input  logic                wr_en_i,
   input  logic [IDX_W-1:0]    wr_idx_i,
   input  logic [OFFSET_W-1:0] wr_off_i,
   input  logic [31:0]         wr_data_i,
   input  logic                rf_en_i,
   input  logic [IDX_W-1:0]    rf_idx_i,
   input  logic [OFFSET_W-1:0] rf_word_i,
   input  logic [31:0]         rf_data_i,
   input  logic                rf_last_i,
   input  logic [TG_W-1:0]     rf_tag_i
);

   logic            valid_q [NUM_LINES];
   logic [TG_W-1:0] tag_q   [NUM_LINES];
   logic [31:0]     data_q  [NUM_LINES][WORDS_PER_LINE];

   // A line only becomes valid once its final refill word lands, so an aborted refill leaves it invalid.
   for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q[gi] <= 1'b0;
         end else if (rf_en_i && rf_last_i && (rf_idx_i == IDX_W'(gi))) begin
            valid_q[gi] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         data_q[wr_idx_i][wr_off_i] <= wr_data_i;
      end
      if (rf_en_i) begin
         data_q[rf_idx_i][rf_word_i] <= rf_data_i;
         if (rf_last_i) begin
            tag_q[rf_idx_i] <= rf_tag_i;
         end
      end
   end

   assign lk_hit_o   = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
   assign lk_rdata_o = data_q[lk_idx_i][lk_off_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with 4-word line refill
// and a fixed MEM_LATENCY access window per memory word.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int NUM_LINES   = 16,
   parameter int MEM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req_valid,
   input  logic        cpu_req_write,
   input  logic [31:0] cpu_req_addr,
   input  logic [31:0] cpu_req_wdata,
   output logic        cpu_req_ready,
   output logic        cpu_resp_valid,
   output logic [31:0] cpu_resp_rdata,
   output logic        mem_store_instruction,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TG_W  = 28 - IDX_W;
   localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

   state_e              state_q;
   logic [LAT_W-1:0]    lat_q;
   logic [1:0]          word_q;
   logic [31:0]         req_addr_q;
   logic [31:0]         resp_word_q;
   logic                resp_valid_q;
   logic [31:0]         resp_rdata_q;
   logic                store_q;
   logic [31:0]         mem_address_q;
   logic [31:0]         mem_data_in_q;
   logic [31:0]         hit_cnt_q;
   logic [31:0]         miss_cnt_q;

   logic                lk_hit;
   logic [31:0]         lk_rdata;
   logic                accept;
   logic                lat_last;
   logic [OFFSET_W-1:0] req_off;
   logic                unused_addr_bits;

   assign accept           = cpu_req_valid && (state_q == ST_IDLE);
   assign lat_last         = (lat_q == LAT_LAST);
   assign req_off          = addr_offset(req_addr_q);
   assign unused_addr_bits = ^cpu_req_addr[1:0];

   dcache_line_array #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TG_W      (TG_W)
   ) u_lines (
      .clk        (clk),
      .rst_n      (reset),
      .lk_idx_i   (IDX_W'(addr_index(cpu_req_addr, IDX_W))),
      .lk_tag_i   (TG_W'(addr_tag(cpu_req_addr, IDX_W))),
      .lk_off_i   (addr_offset(cpu_req_addr)),
      .lk_hit_o   (lk_hit),
      .lk_rdata_o (lk_rdata),
      .wr_en_i    (accept && cpu_req_write && lk_hit),
      .wr_idx_i   (IDX_W'(addr_index(cpu_req_addr, IDX_W))),
      .wr_off_i   (addr_offset(cpu_req_addr)),
      .wr_data_i  (cpu_req_wdata),
      .rf_en_i    ((state_q == ST_REFILL) && lat_last),
      .rf_idx_i   (IDX_W'(addr_index(req_addr_q, IDX_W))),
      .rf_word_i  (word_q),
      .rf_data_i  (mem_data_out),
      .rf_last_i  (word_q == 2'd3),
      .rf_tag_i   (TG_W'(addr_tag(req_addr_q, IDX_W)))
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         lat_q         <= '0;
         word_q        <= 2'd0;
         req_addr_q    <= 32'd0;
         resp_word_q   <= 32'd0;
         resp_valid_q  <= 1'b0;
         resp_rdata_q  <= 32'd0;
         store_q       <= 1'b0;
         mem_address_q <= 32'd0;
         mem_data_in_q <= 32'd0;
         hit_cnt_q     <= 32'd0;
         miss_cnt_q    <= 32'd0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         store_q      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cpu_req_valid) begin
                  if (lk_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
                  else        miss_cnt_q <= miss_cnt_q + 32'd1;
                  req_addr_q <= {cpu_req_addr[31:2], 2'b00};
                  lat_q      <= '0;
                  if (cpu_req_write) begin
                     state_q       <= ST_WRITE;
                     mem_address_q <= {cpu_req_addr[31:2], 2'b00};
                     mem_data_in_q <= cpu_req_wdata;
                     store_q       <= (MEM_LATENCY == 1);
                  end else if (lk_hit) begin
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= lk_rdata;
                  end else begin
                     state_q       <= ST_REFILL;
                     word_q        <= 2'd0;
                     mem_address_q <= {cpu_req_addr[31:4], 4'b0000};
                  end
               end
            end
            ST_REFILL: begin
               if (lat_last) begin
                  lat_q <= '0;
                  if (word_q == req_off) resp_word_q <= mem_data_out;
                  // The requested word is forwarded from the fetch path, never re-read from the array.
                  if (word_q == 2'd3) begin
                     state_q      <= ST_IDLE;
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= (req_off == 2'd3) ? mem_data_out : resp_word_q;
                  end else begin
                     word_q        <= word_q + 2'd1;
                     mem_address_q <= {req_addr_q[31:4], word_q + 2'd1, 2'b00};
                  end
               end else begin
                  lat_q <= lat_q + LAT_W'(1);
               end
            end
            ST_WRITE: begin
               if (lat_last) begin
                  state_q      <= ST_IDLE;
                  resp_valid_q <= 1'b1;
               end else begin
                  lat_q   <= lat_q + LAT_W'(1);
                  store_q <= ((lat_q + LAT_W'(1)) == LAT_LAST);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cpu_req_ready         = (state_q == ST_IDLE);
   assign cpu_resp_valid        = resp_valid_q;
   assign cpu_resp_rdata        = resp_rdata_q;
   assign mem_store_instruction = store_q;
   assign mem_address           = mem_address_q;
   assign mem_data_in           = mem_data_in_q;
   assign hit_count             = hit_cnt_q;
   assign miss_count            = miss_cnt_q;

endmodule
